// File: rtl/logic_pod_ram_writer.sv
// logic_pod_ram_writer: merges NUM_PODS capture streams into one DRAM write
// port. Round-robin grant, one outstanding write, and a private
// 2^REGION_LOG2-word ring per pod (circular or stop-when-full).

// Per-pod ring pointer and status flags.
module logic_pod_ram_writer_pod #(
  parameter int REGION_LOG2 = 20
) (
  input  logic                   clk_ram,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   complete,
  input  logic                   wrap_mode,
  output logic [REGION_LOG2-1:0] ptr,
  output logic                   wrapped,
  output logic                   full
);

  // Clear beats a same-cycle completion; the pointer wraps to 0 in both modes,
  // one-shot mode additionally latches full so the pod stops being granted.
  always_ff @(posedge clk_ram or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      wrapped <= 1'b0;
      full    <= 1'b0;
    end else if (clear) begin
      ptr     <= '0;
      wrapped <= 1'b0;
      full    <= 1'b0;
    end else if (complete) begin
      ptr <= ptr + REGION_LOG2'(1);
      if (&ptr) begin
        if (wrap_mode) wrapped <= 1'b1;
        else           full    <= 1'b1;
      end
    end
  end

endmodule

module logic_pod_ram_writer #(
  parameter int NUM_PODS    = 2,
  parameter int DATA_WIDTH  = 128,
  parameter int REGION_LOG2 = 20,
  parameter int ADDR_WIDTH  = 24
) (
  input  logic                            clk_ram,
  input  logic                            rst_n,
  input  logic [NUM_PODS-1:0]             pod_valid,
  input  logic [NUM_PODS*DATA_WIDTH-1:0]  pod_data,
  output logic [NUM_PODS-1:0]             pod_ready,
  input  logic [NUM_PODS-1:0]             pod_wrap_mode,
  input  logic [NUM_PODS-1:0]             pod_clear,
  input  logic                            ram_ready,
  output logic                            ram_wr_en,
  output logic [ADDR_WIDTH-1:0]           ram_wr_addr,
  output logic [DATA_WIDTH-1:0]           ram_wr_data,
  input  logic                            ram_wr_done,
  output logic [NUM_PODS*REGION_LOG2-1:0] pod_wr_ptr,
  output logic [NUM_PODS-1:0]             pod_wrapped,
  output logic [NUM_PODS-1:0]             pod_full
);

  localparam int GW = (NUM_PODS > 1) ? $clog2(NUM_PODS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t state, state_nxt;

  logic [NUM_PODS-1:0][DATA_WIDTH-1:0]  data_a;
  logic [NUM_PODS-1:0][REGION_LOG2-1:0] ptr_a;
  logic [NUM_PODS-1:0]                  eligible;
  logic [NUM_PODS-1:0]                  pod_complete;
  logic [GW-1:0]                        last_grant;
  logic [GW-1:0]                        grant_q;
  logic [GW-1:0]                        grant_idx;
  logic                                 grant_found;
  logic                                 accept;
  logic                                 complete;
  logic                                 cancel_q;

  assign data_a     = pod_data;
  assign pod_wr_ptr = ptr_a;
  assign eligible   = pod_valid & ~pod_full & ~pod_clear;

  // Round-robin search starting one past the last granted pod.
  always_comb begin
    logic [GW:0] idx;
    idx         = '0;
    grant_found = 1'b0;
    grant_idx   = last_grant;
    for (int k = 1; k <= NUM_PODS; k++) begin
      idx = {1'b0, last_grant} + (GW+1)'(k);
      if (idx >= (GW+1)'(NUM_PODS)) idx = idx - (GW+1)'(NUM_PODS);
      if (!grant_found && eligible[idx[GW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx[GW-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk_ram or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and strobes. pod_ready is masked by rst_n so every output
  // reads 0 while reset is held, even with pods presenting data.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    complete  = 1'b0;
    ram_wr_en = 1'b0;
    pod_ready = '0;
    case (state)
      IDLE: begin
        if (ram_ready && grant_found) begin
          accept               = 1'b1;
          pod_ready[grant_idx] = rst_n;
          state_nxt            = ISSUE;
        end
      end
      ISSUE: begin
        ram_wr_en = 1'b1;
        if (ram_wr_done) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (ram_wr_done) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the granted word/address; remember whether the granted pod was
  // cleared while its write was in flight so the completion is dropped.
  always_ff @(posedge clk_ram or negedge rst_n) begin
    if (!rst_n) begin
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      last_grant  <= GW'(NUM_PODS-1);
      grant_q     <= '0;
      cancel_q    <= 1'b0;
    end else if (accept) begin
      ram_wr_addr <= (ADDR_WIDTH'(grant_idx) << REGION_LOG2) | ADDR_WIDTH'(ptr_a[grant_idx]);
      ram_wr_data <= data_a[grant_idx];
      last_grant  <= grant_idx;
      grant_q     <= grant_idx;
      cancel_q    <= 1'b0;
    end else if (state != IDLE && pod_clear[grant_q]) begin
      cancel_q <= 1'b1;
    end
  end

  // Route the completion to the pod that owns the in-flight write.
  always_comb begin
    pod_complete          = '0;
    pod_complete[grant_q] = complete & ~cancel_q;
  end

  for (genvar i = 0; i < NUM_PODS; i++) begin : g_pod
    logic_pod_ram_writer_pod #(.REGION_LOG2(REGION_LOG2)) u_pod (
      .clk_ram   (clk_ram),
      .rst_n     (rst_n),
      .clear     (pod_clear[i]),
      .complete  (pod_complete[i]),
      .wrap_mode (pod_wrap_mode[i]),
      .ptr       (ptr_a[i]),
      .wrapped   (pod_wrapped[i]),
      .full      (pod_full[i])
    );
  end

endmodule

// File: doc/logic_pod_ram_writer.md
# logic_pod_ram_writer

Parametrised N-pod DRAM write arbiter/address generator sitting between the logic pod capture datapaths and the single DRAM write port, in the `clk_ram` domain. Merges compressed sample words from `NUM_PODS` datapaths into one write stream using round-robin arbitration. Gives each pod a private power-of-two ring region in DRAM with per-pod circular or one-shot (stop-when-full) mode. Reports per-pod write pointer, wrap and full status.

## Interface
Parameters:
- `NUM_PODS`, 2: number of pod channels (1–8).
- `DATA_WIDTH`, 128: DRAM write word width.
- `REGION_LOG2`, 20: log2 of words per pod region.
- `ADDR_WIDTH`, 24: DRAM word address width. Must be ≥ `REGION_LOG2 + clog2(NUM_PODS)`.

Ports:
- `clk_ram` in 1: DRAM user clock; sole clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `pod_valid` in `NUM_PODS`: pod i has a word on its `pod_data` slice.
- `pod_data` in `NUM_PODS*DATA_WIDTH`: slice i = pod i word.
- `pod_ready` out `NUM_PODS`: word accepted when `pod_valid[i] & pod_ready[i]`.
- `pod_wrap_mode` in `NUM_PODS`: 1 = circular, 0 = one-shot.
- `pod_clear` in `NUM_PODS`: one-cycle pulse; resets pod i pointer and flags.
- `ram_ready` in 1: DRAM calibrated and accepting writes.
- `ram_wr_en` out 1: one-cycle write strobe.
- `ram_wr_addr` out `ADDR_WIDTH`: write word address.
- `ram_wr_data` out `DATA_WIDTH`: write data.
- `ram_wr_done` in 1: write completion pulse/level.
- `pod_wr_ptr` out `NUM_PODS*REGION_LOG2`: next write offset per pod.
- `pod_wrapped` out `NUM_PODS`: pod i pointer has wrapped at least once.
- `pod_full` out `NUM_PODS`: one-shot pod i region exhausted.

## Operation
- States: IDLE, ISSUE, WAIT_DONE.
- **Eligibility:** pod i is eligible when `pod_valid[i] & !pod_full[i] & !pod_clear[i]`.
- **IDLE:**
  - If `ram_ready` and any pod is eligible, select g = first eligible pod searching from `last_grant+1` modulo `NUM_PODS`.
  - `pod_ready[g]` = 1 combinationally in this cycle only.
  - Latch `pod_data[g]` and address `{g, ptr[g]}` zero-extended to `ADDR_WIDTH`, i.e. `g*2^REGION_LOG2 + ptr[g]`.
  - Set `last_grant` = g; go to ISSUE.
- **ISSUE:** `ram_wr_en` = 1 for exactly one cycle.
  - If `ram_wr_done` is high this cycle, complete and go to IDLE.
  - Otherwise go to WAIT_DONE.
- **WAIT_DONE:** hold `ram_wr_addr`/`ram_wr_data` stable; on `ram_wr_done`, complete and go to IDLE.
  - `ram_wr_done` in IDLE is ignored.
- **Completion of pod g:** `ptr[g]` += 1 modulo `2^REGION_LOG2`.
  - If old ptr was all-ones and `pod_wrap_mode[g]` = 1: set `pod_wrapped[g]`.
  - If old ptr was all-ones and `pod_wrap_mode[g]` = 0: set `pod_full[g]`; ptr becomes 0.
- **`pod_ready` outside IDLE:** all bits 0 in ISSUE and WAIT_DONE.
- **`pod_clear[i]`:**
  - Next cycle: `ptr[i]` = 0, `pod_wrapped[i]` = 0, `pod_full[i]` = 0.
  - Clear wins over a same-cycle completion for that pod.
  - An in-flight write for pod i still finishes on the DRAM bus but does not advance the cleared pointer.
- **`ram_ready` low:** blocks new grants only; an in-flight write still waits for `ram_wr_done`.
- **Mode change:** `pod_wrap_mode` changes take effect at the next completion; an already-set `pod_full` stays set until clear.

## Timing
- **Reset values:**
  - State IDLE; `last_grant` = `NUM_PODS-1`, so pod 0 has first priority.
  - `ram_wr_en` = 0; `ram_wr_addr` = 0; `ram_wr_data` = 0; `pod_ready` = 0.
  - All ptr, `pod_wrapped`, `pod_full` = 0.
- **Latency:** acceptance in cycle N → `ram_wr_en` in N+1 → earliest next acceptance in N+2.
  - `ram_wr_done` tied high gives one write every 2 cycles.
- **Status update:** `pod_wr_ptr`, `pod_wrapped` and `pod_full` are registered and update the cycle after completion.
- **Reset mid-operation:** `rst_n` low mid-write drops the in-flight write immediately; `ram_wr_en` deasserts asynchronously.
- **Fairness:** with all pods continuously eligible, each pod is granted once per `NUM_PODS` grants.

## Test plan
- **Single pod:** `NUM_PODS`=2, `ram_wr_done`=1, pod0 valid for 4 words D0..D3 → `ram_wr_en` every 2nd cycle, addr 0,1,2,3, data D0..D3, `pod_wr_ptr[0]`=4.
- **Round-robin:** both pods always valid, `REGION_LOG2`=20 → grant order 0,1,0,1; addrs 0, 0x100000, 1, 0x100001.
- **One-shot full:** `REGION_LOG2`=2, mode 0, 6 words offered → 4 writes (addr 0–3), `pod_full[0]`=1, `pod_ready[0]` stays 0. Then `pod_clear[0]` → ptr 0, full 0, next write to addr 0.
- **Circular wrap:** `REGION_LOG2`=2, mode 1, 5 words → addrs 0,1,2,3,0; `pod_wrapped[0]`=1 after 4th completion.
- **Delayed done / not ready:** `ram_wr_done` delayed 5 cycles → addr/data held, no second `ram_wr_en` until done+1. `ram_ready`=0 → no grants with pods valid.
- **Reset mid-write:** `rst_n` low in WAIT_DONE → all outputs 0 immediately. After release, pod0 wins first grant at addr 0.
